// File: rtl/key_scan_pkg.sv
// key_pkg: shared definitions for the push-button scanner.
// Holds the per-channel FSM state encoding, default timing parameters and
// the helper that sizes a counter for a given terminal value.
package key_pkg;

    localparam int unsigned DEF_TICK_DIV    = 32'd50_000;
    localparam int unsigned DEF_DEBOUNCE_MS = 32'd20;
    localparam int unsigned DEF_LONG_MS     = 32'd1000;

    typedef enum logic [2:0] {
        KS_IDLE      = 3'd0,
        KS_PRESS_DEB = 3'd1,
        KS_HELD      = 3'd2,
        KS_LONG_HELD = 3'd3,
        KS_REL_DEB   = 3'd4
    } key_fsm_e;

    // Bits needed to hold every value 0..terminal (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned terminal);
        int unsigned w;
        w = $clog2(terminal + 32'd1);
        if (w < 32'd1) begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one push-button channel.
// Synchronises the raw active-low button, debounces press and release on the
// shared 1 ms tick, tracks hold time and emits one-cycle press, release and
// long-press pulses alongside the registered debounced level.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int unsigned LONG_MS     = DEF_LONG_MS
) (
    input  logic clk_50m,
    input  logic reset_n,
    input  logic tick,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_MS);
    localparam int unsigned HOLD_W = cnt_width(LONG_MS);
    // Counter value seen on the tick that brings it to its terminal value.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 32'd1);

    logic              sync1_r;
    logic              sync2_r;
    logic              raw_s;
    key_fsm_e          fsm_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              long_flag_r;
    logic              key_state_r;
    logic              key_press_r;
    logic              key_release_r;
    logic              key_long_r;

    // Two-flop synchroniser; idles high (released) out of reset.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    assign raw_s = sync2_r;

    // Debounce / hold FSM with registered level and event pulses.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            fsm_r         <= KS_IDLE;
            deb_cnt_r     <= '0;
            hold_cnt_r    <= '0;
            long_flag_r   <= 1'b0;
            key_state_r   <= 1'b0;
            key_press_r   <= 1'b0;
            key_release_r <= 1'b0;
            key_long_r    <= 1'b0;
        end else begin
            key_press_r   <= 1'b0;
            key_release_r <= 1'b0;
            key_long_r    <= 1'b0;
            case (fsm_r)
                KS_IDLE: begin
                    if (!raw_s) begin
                        fsm_r     <= KS_PRESS_DEB;
                        deb_cnt_r <= '0;
                    end
                end
                KS_PRESS_DEB: begin
                    if (raw_s) begin
                        fsm_r <= KS_IDLE;
                    end else if (tick) begin
                        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                        if (deb_cnt_r == DEB_LAST) begin
                            fsm_r       <= KS_HELD;
                            key_press_r <= 1'b1;
                            key_state_r <= 1'b1;
                            hold_cnt_r  <= '0;
                            long_flag_r <= 1'b0;
                        end
                    end
                end
                KS_HELD: begin
                    // A release attempt takes priority over hold counting.
                    if (raw_s) begin
                        fsm_r     <= KS_REL_DEB;
                        deb_cnt_r <= '0;
                    end else if (tick) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        if (hold_cnt_r == HOLD_LAST) begin
                            fsm_r       <= KS_LONG_HELD;
                            key_long_r  <= 1'b1;
                            long_flag_r <= 1'b1;
                        end
                    end
                end
                KS_LONG_HELD: begin
                    if (raw_s) begin
                        fsm_r     <= KS_REL_DEB;
                        deb_cnt_r <= '0;
                    end
                end
                KS_REL_DEB: begin
                    // A bounce returns to the hold state without any event,
                    // so a long press already reported is not repeated.
                    if (!raw_s) begin
                        fsm_r <= long_flag_r ? KS_LONG_HELD : KS_HELD;
                    end else if (tick) begin
                        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                        if (deb_cnt_r == DEB_LAST) begin
                            fsm_r         <= KS_IDLE;
                            key_release_r <= 1'b1;
                            key_state_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                    fsm_r       <= KS_IDLE;
                    deb_cnt_r   <= '0;
                    hold_cnt_r  <= '0;
                    long_flag_r <= 1'b0;
                    key_state_r <= 1'b0;
                end
            endcase
        end
    end

    assign key_state   = key_state_r;
    assign key_press   = key_press_r;
    assign key_release = key_release_r;
    assign key_long    = key_long_r;

endmodule

// File: rtl/key_scan.sv
// key_scan: multi-key push-button scanner.
// A single prescaler derives the 1 ms tick from clk_50m; each key gets an
// independent key_channel that debounces it and reports press, release and
// long-press events.
module key_scan
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 32'd4,
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int unsigned LONG_MS     = DEF_LONG_MS
) (
    input  logic                clk_50m,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned     PRE_W    = cnt_width(TICK_DIV - 32'd1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'd1);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;

    // Free-running 0..TICK_DIV-1 prescaler shared by all channels.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= '0;
        end else if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    assign tick_s = (pre_cnt_r == PRE_LAST);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_chan (
            .clk_50m     (clk_50m),
            .reset_n     (reset_n),
            .tick        (tick_s),
            .key_n       (key_n[g]),
            .key_state   (key_state[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of independent push-button channels.
REQ-002 Parameter TICK_DIV, default 50_000, clk_50m cycles per 1 ms tick.
REQ-003 Parameter DEBOUNCE_MS, default 20, ticks a level must stay stable before it is accepted.
REQ-004 Parameter LONG_MS, default 1000, accepted-hold ticks before a long-press event.
REQ-005 Port clk_50m  input  1  sole clock, 50 MHz.
REQ-006 Port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 Port key_n  input  NUM_KEYS  raw board buttons, asynchronous, active-low (0 = pressed).
REQ-008 Port key_state  output  NUM_KEYS  debounced level, 1 = pressed.
REQ-009 Port key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
REQ-010 Port key_release  output  NUM_KEYS  one-cycle pulse on accepted release.
REQ-011 Port key_long  output  NUM_KEYS  one-cycle pulse when hold reaches LONG_MS.

Function
REQ-012 Each key_n bit SHALL pass a 2-flop synchronizer; the synced level is raw_s (2-cycle latency).
REQ-013 A shared prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for one cycle at TICK_DIV-1.
REQ-014 Each channel SHALL run its own FSM: IDLE, PRESS_DEB, HELD, LONG_HELD, REL_DEB.
REQ-015 IDLE: raw_s=0 -> PRESS_DEB, deb_cnt cleared.
REQ-016 PRESS_DEB: raw_s=1 -> IDLE, no event; else deb_cnt increments on tick; on the tick where deb_cnt reaches DEBOUNCE_MS -> HELD, key_press pulse, key_state=1, hold_cnt and long_flag cleared.
REQ-017 HELD: hold_cnt increments on tick; on the tick where hold_cnt reaches LONG_MS -> LONG_HELD, key_long pulse, long_flag=1; raw_s=1 -> REL_DEB, deb_cnt cleared, hold_cnt kept.
REQ-018 LONG_HELD: hold_cnt frozen; raw_s=1 -> REL_DEB, deb_cnt cleared.
REQ-019 REL_DEB: raw_s=0 -> HELD if long_flag=0, else LONG_HELD, no event; else deb_cnt increments on tick; on the tick where deb_cnt reaches DEBOUNCE_MS -> IDLE, key_release pulse, key_state=0.
REQ-020 All outputs SHALL be registered; a pulse is high exactly the cycle after the transition edge, concurrent with the new key_state.
REQ-021 key_long SHALL fire at most once per press; a bounce during REL_DEB SHALL NOT re-fire key_press or key_long.
REQ-022 Accepted-level delay SHALL be DEBOUNCE_MS to DEBOUNCE_MS+1 ticks plus 2-3 cycles (tick phase).
REQ-023 Counters SHALL be sized with clog2 of their terminal value and SHALL never wrap.
REQ-024 Channels SHALL be fully independent; simultaneous events on several keys SHALL all pulse in the same cycle.

Reset
REQ-025 reset_n low SHALL asynchronously force: synchronizer flops 1, prescaler 0, all FSMs IDLE, all counters and long_flag 0, key_state/key_press/key_release/key_long 0.
REQ-026 Reset asserted mid-hold SHALL produce no release pulse; after deassertion a still-pressed key SHALL be re-debounced and produce a fresh key_press.

Structure
REQ-027 Package key_pkg SHALL hold the FSM state encoding, default TICK_DIV/DEBOUNCE_MS/LONG_MS, and the clog2 width helper.
REQ-028 Sub-module key_channel SHALL implement synchronizer, FSM and counters for one key; key_scan SHALL hold the prescaler and generate NUM_KEYS instances.

Verification (bench parameters TICK_DIV=10, DEBOUNCE_MS=4, LONG_MS=20)
REQ-029 Clean press of key_n[0] held 100 ticks, then release -> key_press[0] after 4-5 ticks, key_long[0] 20 ticks later, key_release[0] 4-5 ticks after release, each exactly 1 cycle.
REQ-030 key_n[1] glitch low for 3 ticks -> no pulses, key_state[1] stays 0.
REQ-031 Press held 10 ticks, 2-tick high bounce, held again, released -> one key_press, no key_long, one key_release.
REQ-032 key_n[0] and key_n[3] pressed same cycle -> key_press 4'b1001 in a single cycle.
REQ-033 reset_n pulsed low while key_n[2] held in LONG_HELD -> all outputs 0 immediately, no key_release; key_press[2] re-fires 4-5 ticks after deassertion.
